// File: rtl/bcd_time_counter.sv
// bcd_time_counter: 24-hour hh:mm:ss time-of-day counter in packed BCD.
// Counts one second per rising edge of the synchronized sec_clk while in the
// RUNNING state, and supports a validated parallel load of all three fields.
// All outputs are registered; tick/rollover/load_err are single-cycle pulses.
module bcd_time_counter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_clk,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       tick,
    output logic       rollover,
    output logic       load_err
);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;
    logic                   sec_edge;

    logic [7:0] hh_reg;
    logic [7:0] mm_reg;
    logic [7:0] ss_reg;
    logic       tick_reg;
    logic       rollover_reg;
    logic       load_err_reg;

    logic [7:0] inc_hh;
    logic [7:0] inc_mm;
    logic [7:0] inc_ss;
    logic       inc_wrap;
    logic       ss_carry;
    logic       mm_carry;

    logic       count_en;
    logic       do_inc;
    logic       load_valid;

    // Synchronizer chain plus history flop; a rising edge is last stage high, history low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], sec_clk};
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign sec_edge = sync_reg[SYNC_STAGES-1] & ~hist_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= STOPPED;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state follows the run level; one cycle of lag is intentional.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            STOPPED: if (run)  state_next = RUNNING;
            RUNNING: if (!run) state_next = STOPPED;
            default:           state_next = STOPPED;
        endcase
    end

    // FSM output: counting is qualified by the registered state; load wins over an edge.
    always_comb begin
        count_en = (state_reg == RUNNING);
        do_inc   = count_en & sec_edge & ~load;
    end

    // Load is acceptable only if every nibble is a decimal digit and each field is in range.
    always_comb begin
        load_valid = (set_hh[7:4] <= 4'd9) && (set_hh[3:0] <= 4'd9) &&
                     (set_mm[7:4] <= 4'd9) && (set_mm[3:0] <= 4'd9) &&
                     (set_ss[7:4] <= 4'd9) && (set_ss[3:0] <= 4'd9) &&
                     (set_hh <= 8'h23) && (set_mm <= 8'h59) && (set_ss <= 8'h59);
    end

    // BCD increment with digit-by-digit carry; hours wrap 23 -> 00.
    always_comb begin
        inc_ss   = ss_reg;
        inc_mm   = mm_reg;
        inc_hh   = hh_reg;
        inc_wrap = 1'b0;
        ss_carry = 1'b0;
        mm_carry = 1'b0;

        if (ss_reg[3:0] != 4'd9) begin
            inc_ss[3:0] = ss_reg[3:0] + 4'd1;
        end else begin
            inc_ss[3:0] = 4'd0;
            if (ss_reg[7:4] != 4'd5) begin
                inc_ss[7:4] = ss_reg[7:4] + 4'd1;
            end else begin
                inc_ss[7:4] = 4'd0;
                ss_carry    = 1'b1;
            end
        end

        if (ss_carry) begin
            if (mm_reg[3:0] != 4'd9) begin
                inc_mm[3:0] = mm_reg[3:0] + 4'd1;
            end else begin
                inc_mm[3:0] = 4'd0;
                if (mm_reg[7:4] != 4'd5) begin
                    inc_mm[7:4] = mm_reg[7:4] + 4'd1;
                end else begin
                    inc_mm[7:4] = 4'd0;
                    mm_carry    = 1'b1;
                end
            end
        end

        if (mm_carry) begin
            if (hh_reg == 8'h23) begin
                inc_hh   = 8'h00;
                inc_wrap = 1'b1;
            end else if (hh_reg[3:0] == 4'd9) begin
                inc_hh[3:0] = 4'd0;
                inc_hh[7:4] = hh_reg[7:4] + 4'd1;
            end else begin
                inc_hh[3:0] = hh_reg[3:0] + 4'd1;
            end
        end
    end

    // Time registers and single-cycle status pulses; priority reset > load > edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hh_reg       <= 8'h00;
            mm_reg       <= 8'h00;
            ss_reg       <= 8'h00;
            tick_reg     <= 1'b0;
            rollover_reg <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            tick_reg     <= 1'b0;
            rollover_reg <= 1'b0;
            load_err_reg <= 1'b0;
            if (load) begin
                if (load_valid) begin
                    hh_reg <= set_hh;
                    mm_reg <= set_mm;
                    ss_reg <= set_ss;
                end else begin
                    load_err_reg <= 1'b1;
                end
            end else if (do_inc) begin
                hh_reg       <= inc_hh;
                mm_reg       <= inc_mm;
                ss_reg       <= inc_ss;
                tick_reg     <= 1'b1;
                rollover_reg <= inc_wrap;
            end
        end
    end

    assign hh       = hh_reg;
    assign mm       = mm_reg;
    assign ss       = ss_reg;
    assign tick     = tick_reg;
    assign rollover = rollover_reg;
    assign load_err = load_err_reg;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Testbench for bcd_time_counter: table-driven load checks plus hand-written
// sequences for counting, carries, rollover, load/edge collision, stop and reset.
module tb_bcd_time_counter;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sec_clk = 1'b0;
    logic       run = 1'b0;
    logic       load = 1'b0;
    logic [7:0] set_hh = 8'h00;
    logic [7:0] set_mm = 8'h00;
    logic [7:0] set_ss = 8'h00;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       tick;
    logic       rollover;
    logic       load_err;

    bcd_time_counter #(.SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .reset    (reset),
        .sec_clk  (sec_clk),
        .run      (run),
        .load     (load),
        .set_hh   (set_hh),
        .set_mm   (set_mm),
        .set_ss   (set_ss),
        .hh       (hh),
        .mm       (mm),
        .ss       (ss),
        .tick     (tick),
        .rollover (rollover),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       tick;
        logic       roll;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] ld_hh;
        logic [7:0] ld_mm;
        logic [7:0] ld_ss;
        logic [7:0] e_hh;
        logic [7:0] e_mm;
        logic [7:0] e_ss;
        logic       e_err;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                            input logic t, input logic r, input logic e);
        exp_t x;
        x.hh = h; x.mm = m; x.ss = s; x.tick = t; x.roll = r; x.err = e;
        sb_q.push_back(x);
    endtask

    // Pop the oldest expectation and compare it with the outputs sampled now.
    task automatic check_out(input string name);
        exp_t x;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            x = sb_q.pop_front();
            chk({name, ".hh"},       32'(hh),       32'(x.hh));
            chk({name, ".mm"},       32'(mm),       32'(x.mm));
            chk({name, ".ss"},       32'(ss),       32'(x.ss));
            chk({name, ".tick"},     32'(tick),     32'(x.tick));
            chk({name, ".rollover"}, 32'(rollover), 32'(x.roll));
            chk({name, ".load_err"}, 32'(load_err), 32'(x.err));
            $display("%-16s time %02h:%02h:%02h tick=%0b roll=%0b err=%0b", name, hh, mm, ss,
                     tick, rollover, load_err);
        end
    endtask

    // Single-cycle load; result visible the cycle after the strobe.
    task automatic do_load(input string name, input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] s, input logic [7:0] eh, input logic [7:0] em,
                           input logic [7:0] es, input logic eerr);
        @(negedge clk);
        load = 1'b1; set_hh = h; set_mm = m; set_ss = s;
        push_exp(eh, em, es, 1'b0, 1'b0, eerr);
        @(negedge clk);
        load = 1'b0;
        check_out(name);
        @(negedge clk);
        chk({name, ".err_width"}, 32'(load_err), 32'(0));
    endtask

    // One sec_clk period (20 high / 20 low); checks tick count, latency and final time.
    task automatic sec_period(input string name, input logic [7:0] eh, input logic [7:0] em,
                              input logic [7:0] es, input logic etick, input logic eroll);
        int tick_cnt;
        int tick_at;
        int roll_cnt;
        int roll_tick_cnt;
        tick_cnt = 0; tick_at = -1; roll_cnt = 0; roll_tick_cnt = 0;
        @(negedge clk);
        sec_clk = 1'b1;
        push_exp(eh, em, es, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tick) begin
                tick_cnt++;
                tick_at = i;
            end
            if (rollover) roll_cnt++;
            if (rollover && tick) roll_tick_cnt++;
            if (i == 19) sec_clk = 1'b0;
        end
        chk({name, ".ticks"}, 32'(tick_cnt), 32'(etick ? 1 : 0));
        if (etick) chk({name, ".latency"}, 32'(tick_at), 32'(SYNC));
        chk({name, ".rolls"}, 32'(roll_cnt), 32'(eroll ? 1 : 0));
        chk({name, ".roll_with_tick"}, 32'(roll_tick_cnt), 32'(eroll ? 1 : 0));
        check_out(name);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int tick_cnt;

        vecs[0] = '{8'h24, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 1'b1};
        vecs[1] = '{8'h12, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h03, 1'b1};
        vecs[2] = '{8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56, 1'b0};
        vecs[3] = '{8'h23, 8'h59, 8'h59, 8'h23, 8'h59, 8'h59, 1'b0};
        vecs[4] = '{8'h1A, 8'h00, 8'h00, 8'h23, 8'h59, 8'h59, 1'b1};
        vecs[5] = '{8'h00, 8'h60, 8'h00, 8'h23, 8'h59, 8'h59, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 8'h60, 8'h23, 8'h59, 8'h59, 1'b1};
        vecs[7] = '{8'h00, 8'h00, 8'h0A, 8'h23, 8'h59, 8'h59, 1'b1};
        vecs[8] = '{8'h09, 8'h59, 8'h59, 8'h09, 8'h59, 8'h59, 1'b0};

        // Reset held for 3 cycles with sec_clk toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sec_clk = ~sec_clk;
        end
        push_exp(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        check_out("in_reset");
        @(negedge clk);
        sec_clk = 1'b0;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        push_exp(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        check_out("after_reset");

        // Edges while stopped are discarded.
        sec_period("stopped_edge", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Basic counting.
        @(negedge clk);
        run = 1'b1;
        repeat (2) @(negedge clk);
        sec_period("count_1", 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
        sec_period("count_2", 8'h00, 8'h00, 8'h02, 1'b1, 1'b0);
        sec_period("count_3", 8'h00, 8'h00, 8'h03, 1'b1, 1'b0);

        // Load validation table.
        for (int i = 0; i < 9; i++) begin
            do_load($sformatf("load_vec%0d", i), vecs[i].ld_hh, vecs[i].ld_mm, vecs[i].ld_ss,
                    vecs[i].e_hh, vecs[i].e_mm, vecs[i].e_ss, vecs[i].e_err);
        end

        // Carries: 09:59:59 -> 10:00:00, then 23:59:59 -> 00:00:00 with rollover.
        sec_period("carry_hours", 8'h10, 8'h00, 8'h00, 1'b1, 1'b0);
        do_load("load_2359", 8'h23, 8'h59, 8'h59, 8'h23, 8'h59, 8'h59, 1'b0);
        sec_period("rollover", 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);

        // Load coincident with the edge: loaded value wins, no tick.
        @(negedge clk);
        sec_clk = 1'b1;
        tick_cnt = 0;
        @(negedge clk);
        if (tick) tick_cnt++;
        @(negedge clk);
        if (tick) tick_cnt++;
        load = 1'b1; set_hh = 8'h05; set_mm = 8'h06; set_ss = 8'h07;
        push_exp(8'h05, 8'h06, 8'h07, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        load = 1'b0;
        check_out("collision");
        for (int i = 3; i < 40; i++) begin
            @(negedge clk);
            if (tick) tick_cnt++;
            if (i == 19) sec_clk = 1'b0;
        end
        chk("collision.ticks", 32'(tick_cnt), 32'(0));

        // Stop: five edges, time frozen.
        @(negedge clk);
        run = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            sec_period($sformatf("stopped_%0d", i), 8'h05, 8'h06, 8'h07, 1'b0, 1'b0);
        end

        // Resume: exactly one increment.
        @(negedge clk);
        run = 1'b1;
        repeat (2) @(negedge clk);
        sec_period("resume", 8'h05, 8'h06, 8'h08, 1'b1, 1'b0);

        // Reset in the cycle the edge fires.
        do_load("load_0708", 8'h07, 8'h08, 8'h09, 8'h07, 8'h08, 8'h09, 1'b0);
        @(negedge clk);
        sec_clk = 1'b1;
        tick_cnt = 0;
        @(negedge clk);
        if (tick) tick_cnt++;
        @(negedge clk);
        if (tick) tick_cnt++;
        reset = 1'b0;
        run = 1'b0;
        push_exp(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        check_out("reset_mid");
        for (int i = 3; i < 40; i++) begin
            @(negedge clk);
            if (tick) tick_cnt++;
            if (i == 19) sec_clk = 1'b0;
        end
        chk("reset_mid.ticks", 32'(tick_cnt), 32'(0));
        chk("reset_mid.ss_hold", 32'(ss), 32'(8'h00));

        // Counting resumes from zero once run is reasserted.
        @(negedge clk);
        run = 1'b1;
        repeat (2) @(negedge clk);
        sec_period("post_reset", 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

Time-of-day counter that consumes the 1 Hz square wave produced by the clock divider and keeps hours:minutes:seconds in packed BCD, 24-hour format. It runs in the same 10 MHz `clk` domain as the divider. It synchronizes the slow clock and counts one second per rising edge of it. It supports run/stop control and a validated parallel time load. Its outputs drive the display/decoder stage directly.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops on `sec_clk`; legal range 2–3.

- `clk`  in  1  system clock (10 MHz); all logic on rising edge.
- `reset`  in  1  reset: one clock; reset is synchronous and active-low.
- `sec_clk`  in  1  slow square wave from the divider; each rising edge is one second.
- `run`  in  1  level; 1 = count, 0 = hold.
- `load`  in  1  single-cycle strobe; loads `set_hh/set_mm/set_ss`.
- `set_hh`  in  8  BCD hours to load, {tens, units}.
- `set_mm`  in  8  BCD minutes to load.
- `set_ss`  in  8  BCD seconds to load.
- `hh`  out  8  current hours, BCD 00–23.
- `mm`  out  8  current minutes, BCD 00–59.
- `ss`  out  8  current seconds, BCD 00–59.
- `tick`  out  1  one-cycle pulse in the cycle a new incremented time first appears on the outputs.
- `rollover`  out  1  one-cycle pulse coincident with the `tick` that wraps 23:59:59 → 00:00:00.
- `load_err`  out  1  one-cycle pulse when a `load` is rejected.

## Operation
- **Synchronizer:** `sec_clk` passes through `SYNC_STAGES` flops, then a history flop. `edge` = last stage & ~history. All of these flops reset to 0.
- **State machine:** two states, STOPPED and RUNNING; reset enters STOPPED.
  - STOPPED → RUNNING on any cycle with `run`=1.
  - RUNNING → STOPPED on any cycle with `run`=0.
  - Counting is qualified by the registered state, not by raw `run`.
- **Dropped edges:** an `edge` seen while STOPPED is discarded, never queued.
- **Increment on `edge` in RUNNING:**
  - `ss` units 9→0 carries to `ss` tens; `ss` 59→00 carries to `mm`.
  - `mm` 59→00 carries to `hh`.
  - `hh` 23→00 with a carry asserts `rollover`.
  - Every nibble stays in 0–9, and tens digits stay within range.
- **Load validation:** a `load` is valid when every nibble is ≤9, `set_hh` ≤ 0x23, `set_mm` ≤ 0x59, and `set_ss` ≤ 0x59.
  - Valid: all three fields are replaced at the next edge.
  - Invalid: outputs are unchanged and `load_err` pulses.
  - Load is accepted in either state and never changes the state.
- **Priority:** `reset` > `load` > `edge`.
  - When `load` (valid or invalid) and an `edge` coincide, the edge is dropped and `tick`/`rollover` stay 0 that cycle.
- **Reset values:** `hh`, `mm`, `ss` = 0x00; `tick`, `rollover`, `load_err` = 0; state STOPPED.
- **Reset mid-operation:** aborts any in-flight increment; the partially synchronized edge is lost.
- **High `sec_clk` at reset release:** produces one `edge`. This edge is counted only if RUNNING by then. It is normally absent because the divider holds its output low in reset.

## Timing
- **Edge latency:** let edge k be the first `clk` edge that samples `sec_clk` high. Then:
  - `hh/mm/ss` update and `tick` is high in the cycle starting at edge k+`SYNC_STAGES`.
  - With the default, that is 2 clocks after sampling.
- **Load:** `load` sampled high at edge n → new values (or `load_err`) visible after edge n+1, i.e. 1-cycle latency.
- **Run/stop:** `run` sampled at edge n changes the state at edge n+1. An `edge` evaluated in that same cycle n still uses the old state.
- **Pulse width:** `tick`, `rollover` and `load_err` are registered and exactly 1 cycle wide. With a 10 MHz `clk` and 1 Hz `sec_clk`, `tick` pulses are 10,000,000 cycles apart.
- **Edge spacing:** `sec_clk` high and low phases must each be ≥ `SYNC_STAGES`+1 clk cycles. Narrower pulses may be missed.
- **Glitch-free outputs:** all outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with `sec_clk` toggling.
  - Outputs 00:00:00, all pulses 0.
  - No tick until `run`=1.
- **Basic count:** `run`=1, 3 `sec_clk` rising edges (20 clk high / 20 low).
  - `ss` = 0x01, 0x02, 0x03.
  - Each update occurs exactly 2 clks after sampling, with one `tick` each.
- **Carries:** load 09:59:59 then one edge → 10:00:00, no `rollover`. Load 23:59:59 then one edge → 00:00:00 with `tick` and `rollover` high in the same cycle.
- **Load validation:**
  - Load 24:00:00, then 12:5A:00 → `load_err` pulses each time, outputs unchanged.
  - Load 12:34:56 → outputs 12:34:56 the next cycle, `load_err`=0.
- **Collision and stop:**
  - `load` asserted in the cycle `edge` fires → loaded value shown, no `tick`.
  - `run`=0, then 5 `sec_clk` edges → outputs frozen.
  - `run`=1 → next edge increments by exactly 1.
- **Reset mid-operation:** at 07:08:09, assert `reset` in the cycle `edge` fires → 00:00:00, no `tick`, state STOPPED.
